// File: rtl/axi_write_arbiter.sv
// N-to-1 AXI write-channel arbiter: grants one requester per burst (AW then W beats until last).
// Define AXI_WRITE_ARBITER_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module axi_write_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned AW_W = 64,
  parameter int unsigned W_W  = 73,
  localparam int unsigned IW  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [N-1:0]        m_aw_valid,
  output logic [N-1:0]        m_aw_ready,
  input  logic [N*AW_W-1:0]   m_aw_data,

  input  logic [N-1:0]        m_w_valid,
  output logic [N-1:0]        m_w_ready,
  input  logic [N*W_W-1:0]    m_w_data,
  input  logic [N-1:0]        m_w_last,

  output logic                s_aw_valid,
  input  logic                s_aw_ready,
  output logic [AW_W-1:0]     s_aw_data,
  output logic [IW-1:0]       s_aw_idx,

  output logic                s_w_valid,
  input  logic                s_w_ready,
  output logic [W_W-1:0]      s_w_data,
  output logic                s_w_last
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] prio_q, prio_d;

  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [IW-1:0] grant_nxt;
  logic          w_done;

  logic [AW_W-1:0] aw_arr [N];
  logic [W_W-1:0]  w_arr  [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign aw_arr[i] = m_aw_data[i*AW_W +: AW_W];
    assign w_arr[i]  = m_w_data[i*W_W +: W_W];
  end

  // Scan p, p+1, ... wrapping at N; the sum carries one extra bit so the wrap is exact for any N.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, prio_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      idx = sum[IW-1:0];
      if (!pick_vld && m_aw_valid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign grant_nxt = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
  assign w_done    = m_w_valid[grant_q] && s_w_ready && m_w_last[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (s_aw_ready) begin
          state_d = StData;
        end
      end
      StData: begin
        if (w_done) begin
          state_d = StIdle;
`ifdef AXI_WRITE_ARBITER_FIXED_PRIO_EN
          prio_d  = '0;
`else
          prio_d  = grant_nxt;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  // Valids depend only on registered state and requester valids, never on the downstream readies.
  always_comb begin
    s_aw_valid = (state_q == StAddr);
    s_aw_data  = aw_arr[grant_q];
    s_aw_idx   = grant_q;
    s_w_valid  = (state_q == StData) && m_w_valid[grant_q];
    s_w_data   = w_arr[grant_q];
    s_w_last   = (state_q == StData) && m_w_last[grant_q];
    m_aw_ready = '0;
    m_w_ready  = '0;
    if (state_q == StAddr) begin
      m_aw_ready[grant_q] = s_aw_ready;
    end
    if (state_q == StData) begin
      m_w_ready[grant_q] = s_w_ready;
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter (N=2): burst table driven through a scoreboard.
module tb_axi_write_arbiter;

  localparam int unsigned N    = 2;
  localparam int unsigned AW_W = 64;
  localparam int unsigned W_W  = 73;
  localparam int unsigned IW   = 1;
`ifdef AXI_WRITE_ARBITER_FIXED_PRIO_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_aw_valid, m_aw_ready;
  logic [N*AW_W-1:0] m_aw_data;
  logic [N-1:0]      m_w_valid, m_w_ready, m_w_last;
  logic [N*W_W-1:0]  m_w_data;
  logic              s_aw_valid, s_aw_ready;
  logic [AW_W-1:0]   s_aw_data;
  logic [IW-1:0]     s_aw_idx;
  logic              s_w_valid, s_w_ready, s_w_last;
  logic [W_W-1:0]    s_w_data;

  typedef struct {
    logic [N-1:0] mask;
    int           exp_rr;
    int           exp_fp;
    int           beats;
    bit           toggle;
    int           aw_stall;
    int           rst_beat;
  } vec_t;

  vec_t               vecs [13];
  logic [AW_W+IW-1:0] aw_q [$];
  logic [W_W:0]       w_q  [$];
  int                 errors = 0;
  int                 checks = 0;

  always #5 clk = ~clk;

  axi_write_arbiter #(.N(N), .AW_W(AW_W), .W_W(W_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .m_aw_valid (m_aw_valid),
    .m_aw_ready (m_aw_ready),
    .m_aw_data  (m_aw_data),
    .m_w_valid  (m_w_valid),
    .m_w_ready  (m_w_ready),
    .m_w_data   (m_w_data),
    .m_w_last   (m_w_last),
    .s_aw_valid (s_aw_valid),
    .s_aw_ready (s_aw_ready),
    .s_aw_data  (s_aw_data),
    .s_aw_idx   (s_aw_idx),
    .s_w_valid  (s_w_valid),
    .s_w_ready  (s_w_ready),
    .s_w_data   (s_w_data),
    .s_w_last   (s_w_last)
  );

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [AW_W-1:0] aw_pl(int i, int r);
    return {16'hA5A5, 16'(i), 32'(r * 7 + i + 1)};
  endfunction

  function automatic logic [W_W-1:0] w_pl(int i, int r, int b);
    return {9'(i + 1), 32'(r), 32'(b * 3 + 5)};
  endfunction

  task automatic run_burst(input int r, input vec_t v);
    int                 g, sent, cyc, stall;
    bit                 aw_done, aw_hs, w_hs, held_v, done;
    logic [AW_W+IW-1:0] held, exp_aw;
    logic [W_W:0]       exp_w;
    logic [N-1:0]       onehot;
    g = Fixed ? v.exp_fp : v.exp_rr;
    onehot    = '0;
    onehot[g] = 1'b1;
    aw_q.push_back({IW'(g), aw_pl(g, r)});
    for (int b = 0; b < v.beats; b++) w_q.push_back({(b == v.beats - 1), w_pl(g, r, b)});

    @(negedge clk);
    m_aw_valid = v.mask;
    for (int i = 0; i < N; i++) m_aw_data[i*AW_W +: AW_W] = aw_pl(i, r);
    // W beat is presented before the AW handshake and must be held back
    m_w_valid = onehot;
    m_w_last  = (v.beats == 1) ? onehot : '0;
    m_w_data  = '0;
    m_w_data[g*W_W +: W_W] = w_pl(g, r, 0);
    stall      = v.aw_stall;
    s_aw_ready = (stall == 0);
    s_w_ready  = 1'b1;
    sent = 0; cyc = 0; aw_done = 0; held_v = 0; done = 0; held = '0;

    while (!done && cyc < 200) begin
      #1;
      aw_hs = s_aw_valid && s_aw_ready;
      w_hs  = s_w_valid && s_w_ready;
      if (cyc == 0) chk("aw_latency_idle", s_aw_valid, 1'b0);
      if (cyc == 1) chk("aw_latency_addr", s_aw_valid, 1'b1);
      if (!aw_done) chk("w_held_before_aw", {s_w_valid, m_w_ready}, '0);
      if (s_aw_valid) begin
        if (held_v) chk("aw_stable", {s_aw_idx, s_aw_data}, held);
        held   = {s_aw_idx, s_aw_data};
        held_v = 1'b1;
        if (aw_hs) begin
          if (aw_q.size() == 0) chk("aw_q_underflow", aw_q.size(), 1);
          else begin
            exp_aw = aw_q.pop_front();
            chk("aw_grant", {s_aw_idx, s_aw_data}, exp_aw);
          end
          chk("aw_ready_grant", m_aw_ready, onehot);
          aw_done = 1'b1;
        end else begin
          chk("aw_ready_stall", m_aw_ready, '0);
        end
      end
      if (w_hs) begin
        if (w_q.size() == 0) chk("w_q_underflow", w_q.size(), 1);
        else begin
          exp_w = w_q.pop_front();
          chk("w_beat", {s_w_last, s_w_data}, exp_w);
        end
        chk("w_ready_grant", m_w_ready, onehot);
        sent++;
        done = (sent == v.beats);
      end
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (aw_done) m_aw_valid = '0;
        if (held_v && !aw_done && stall > 0) stall--;
        s_aw_ready = (stall == 0);
        if (v.toggle) s_w_ready = aw_hs ? 1'b1 : ~s_w_ready;
        else s_w_ready = 1'b1;
        if (w_hs) begin
          m_w_data[g*W_W +: W_W] = w_pl(g, r, sent);
          m_w_last = (sent == v.beats - 1) ? onehot : '0;
        end
        if (v.rst_beat != 0 && sent == v.rst_beat) begin
          rst = 1'b1;
          @(posedge clk);
          @(negedge clk);
          rst        = 1'b0;
          m_aw_valid = '0;
          #1;
          chk("reset_mid_burst", {s_aw_valid, s_w_valid, m_aw_ready, m_w_ready}, '0);
          w_q.delete();
          m_w_valid  = '0;
          m_w_last   = '0;
          s_aw_ready = 1'b0;
          return;
        end
      end
    end
    chk("burst_beats", sent, v.beats);

    @(posedge clk);
    @(negedge clk);
    m_aw_valid = '0;
    m_w_valid  = '0;
    m_w_last   = '0;
    s_aw_ready = 1'b0;
    s_w_ready  = 1'b1;
    #1;
    chk("idle_out", {s_aw_valid, s_w_valid, m_aw_ready, m_w_ready}, '0);
  endtask

  initial begin
    //             mask   rr fp beats tog stall rstb
    vecs[0]  = '{2'b11, 0, 0, 1, 1'b0, 0, 0};
    vecs[1]  = '{2'b11, 1, 0, 2, 1'b0, 0, 0};
    vecs[2]  = '{2'b11, 0, 0, 1, 1'b0, 0, 0};
    vecs[3]  = '{2'b01, 0, 0, 3, 1'b0, 0, 0};
    vecs[4]  = '{2'b10, 1, 1, 1, 1'b0, 0, 0};
    vecs[5]  = '{2'b10, 1, 1, 2, 1'b0, 0, 0};
    vecs[6]  = '{2'b11, 0, 0, 1, 1'b0, 5, 0};
    vecs[7]  = '{2'b01, 0, 0, 4, 1'b1, 0, 0};
    vecs[8]  = '{2'b11, 1, 0, 1, 1'b0, 0, 0};
    vecs[9]  = '{2'b01, 0, 0, 1, 1'b0, 0, 0};
    vecs[10] = '{2'b10, 1, 1, 4, 1'b0, 0, 1};
    vecs[11] = '{2'b11, 0, 0, 1, 1'b0, 0, 0};
    vecs[12] = '{2'b11, 1, 0, 2, 1'b1, 0, 0};

    rst        = 1'b1;
    m_aw_valid = '0;
    m_aw_data  = '0;
    m_w_valid  = '0;
    m_w_data   = '0;
    m_w_last   = '0;
    s_aw_ready = 1'b0;
    s_w_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_idle", {s_aw_valid, s_w_valid, m_aw_ready, m_w_ready}, '0);
    m_aw_valid = 2'b11;
    m_w_valid  = 2'b11;
    s_aw_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_held_req", {s_aw_valid, s_w_valid, m_aw_ready, m_w_ready}, '0);
    m_aw_valid = '0;
    m_w_valid  = '0;
    s_aw_ready = 1'b0;
    rst        = 1'b0;

    for (int k = 0; k < 13; k++) run_burst(k, vecs[k]);

    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty", w_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/axi_write_arbiter.md
AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 Parameter N, default 2, number of write requesters, legal range 2..8.
REQ-002 Parameter AW_W, default 64, packed AW payload width (id, addr, len, size, burst, lock, cache, prot, qos, region, user).
REQ-003 Parameter W_W, default 73, packed W payload width (data, strb, user), excluding last.
REQ-004 Localparam IW = $clog2(N).
REQ-005 Port clk, in, 1: single clock; one clock; reset is synchronous and active-high.
REQ-006 Port rst, in, 1: synchronous, active-high reset.
REQ-007 m_aw_valid in N; m_aw_ready out N; m_aw_data in N*AW_W: per-requester AW, requester i at slice [i*AW_W +: AW_W].
REQ-008 m_w_valid in N; m_w_ready out N; m_w_data in N*W_W; m_w_last in N: per-requester W.
REQ-009 s_aw_valid out 1; s_aw_ready in 1; s_aw_data out AW_W; s_aw_idx out IW: arbitrated AW plus winning requester index.
REQ-010 s_w_valid out 1; s_w_ready in 1; s_w_data out W_W; s_w_last out 1: arbitrated W.

Function
REQ-011 FSM states IDLE, ADDR, DATA; registered grant index g (IW bits); registered priority pointer p (IW bits).
REQ-012 IDLE: if any m_aw_valid, g <= first index with m_aw_valid set, scanning p, p+1, ... wrapping mod N; state <= ADDR; else stay.
REQ-013 ADDR: s_aw_valid=1, s_aw_data=m_aw_data[g], s_aw_idx=g; m_aw_ready[g]=s_aw_ready; on s_aw_ready state <= DATA.
REQ-014 DATA: s_w_valid=m_w_valid[g], s_w_data=m_w_data[g], s_w_last=m_w_last[g], m_w_ready[g]=s_w_ready.
REQ-015 DATA: on s_w_valid & s_w_ready & s_w_last, state <= IDLE and p <= (g+1) mod N (wrap at N, not 2^IW).
REQ-016 Latency: first m_aw_valid in IDLE -> s_aw_valid next cycle; minimum 3 cycles per single-beat burst (IDLE, ADDR, DATA).
REQ-017 All m_aw_ready/m_w_ready bits other than g are 0 in every state; all are 0 in IDLE.
REQ-018 s_w_valid=0 outside DATA; W beats presented before their AW handshake are held, never dropped.
REQ-019 s_aw_valid once asserted stays 1 with stable s_aw_data/s_aw_idx until s_aw_ready.
REQ-020 Requester deasserting m_aw_valid after grant is an AXI violation; behaviour unspecified.
REQ-021 Simultaneous new AW requests during ADDR/DATA are ignored until return to IDLE.
REQ-022 No combinational path from s_aw_ready/s_w_ready to s_aw_valid/s_w_valid.

Reset
REQ-023 rst sampled on clk: state <= IDLE, g <= 0, p <= 0.
REQ-024 During/after reset: s_aw_valid, s_w_valid, all m_aw_ready, all m_w_ready = 0.
REQ-025 Reset mid-burst abandons the burst; remaining beats are not forwarded.

Configuration
REQ-026 Macro AXI_WRITE_ARBITER_FIXED_PRIO_EN defined: IDLE selection always scans from index 0 (lowest index wins); p unused, held 0.
REQ-027 Macro undefined: round-robin per REQ-012/REQ-015.

Verification (N=2, round-robin unless stated)
REQ-028 After reset, m_aw_valid=2'b11, s_aw_ready=1 -> s_aw_idx=0 granted first; after its last beat, requester 1 granted; then requester 0 again.
REQ-029 Requester 0 AW len=3, m_w_valid held 1, s_w_ready toggling 1,0,1,0 -> exactly 4 beats forwarded in order, s_w_last only on 4th, state returns IDLE.
REQ-030 Requester 1 asserts m_w_valid two cycles before m_aw_valid -> m_w_ready[1]=0 until AW handshake completes; no beat lost.
REQ-031 s_aw_ready held 0 for 5 cycles in ADDR -> s_aw_valid, s_aw_data stable all 5 cycles; m_aw_ready[g]=0.
REQ-032 rst asserted for 1 cycle on 2nd beat of a 4-beat burst -> next cycle all valid/ready outputs 0, p=0; next grant from index 0.
REQ-033 With AXI_WRITE_ARBITER_FIXED_PRIO_EN, m_aw_valid=2'b11 held for 3 bursts -> s_aw_idx=0 every grant.
